// File: rtl/dma_wr_stream_checker.sv
// dma_wr_stream_checker
//   Per-channel checker for the scope acquisition write path. It counts ADC
//   buffer writes and AXI HP write-data samples, and tracks the signed lag
//   between them. Lag overflow, AXI-ahead-of-ADC and illegal write strobes are
//   reported as sticky error flags. The first trigger edge after a clear
//   snapshots every channel's ADC count. A registered read-back mux returns one
//   channel's results at a time.
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   en_i, clr_i           count enable, synchronous clear
//   adc_we_i              per-channel ADC buffer write strobe
//   axi_wvalid_i/wready_i per-channel W handshake
//   axi_wstrb_i           per-channel write strobes, AXI_DW/8 bits each
//   trig_i                acquisition trigger level
//   rd_ch_i               read-back channel select
//   rd_*_o                registered read-back of the selected channel
//   trig_seen_o           trigger snapshot valid
//   err_lag_o/under_o/strb_o  sticky per-channel error flags
module dma_wr_stream_checker #(
    parameter int NUM_CH  = 4,
    parameter int AXI_DW  = 64,
    parameter int CNT_W   = 32,
    parameter int MAX_LAG = 256,
    localparam int SW     = AXI_DW / 8,
    localparam int RD_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   clr_i,
    input  logic [NUM_CH-1:0]      adc_we_i,
    input  logic [NUM_CH-1:0]      axi_wvalid_i,
    input  logic [NUM_CH-1:0]      axi_wready_i,
    input  logic [NUM_CH*SW-1:0]   axi_wstrb_i,
    input  logic                   trig_i,
    input  logic [RD_W-1:0]        rd_ch_i,
    output logic [CNT_W-1:0]       rd_adc_cnt_o,
    output logic [CNT_W-1:0]       rd_axi_cnt_o,
    output logic [CNT_W:0]         rd_lag_o,
    output logic [CNT_W-1:0]       rd_trig_cnt_o,
    output logic                   trig_seen_o,
    output logic [NUM_CH-1:0]      err_lag_o,
    output logic [NUM_CH-1:0]      err_under_o,
    output logic [NUM_CH-1:0]      err_strb_o
);
    localparam int LANES = AXI_DW / 16;
    localparam int NW    = $clog2(LANES + 1);
    // Lag arithmetic is done one bit wider than the lag register so the
    // saturation check can see the overflow.
    localparam int LW    = CNT_W + 2;
    localparam logic signed [LW-1:0] LAG_HI  = $signed({2'b00, {CNT_W{1'b1}}});
    localparam logic signed [LW-1:0] LAG_LO  = $signed({2'b11, {CNT_W{1'b0}}});
    localparam logic signed [LW-1:0] LAG_MAX = LW'(MAX_LAG);
    localparam logic [SW-1:0]        ONES    = '1;

    logic [CNT_W-1:0] adc_cnt_q  [NUM_CH];
    logic [CNT_W-1:0] axi_cnt_q  [NUM_CH];
    logic [CNT_W:0]   lag_q      [NUM_CH];
    logic [CNT_W-1:0] trig_cnt_q [NUM_CH];
    logic [NUM_CH-1:0] err_lag_q, err_under_q, err_strb_q;
    logic trig_seen_q, trig_q, trig_dly_q;
    logic [CNT_W-1:0] rd_adc_q, rd_axi_q, rd_trig_q;
    logic [CNT_W:0]   rd_lag_q;

    logic [CNT_W-1:0] adc_cnt_d  [NUM_CH];
    logic [CNT_W-1:0] axi_cnt_d  [NUM_CH];
    logic [CNT_W:0]   lag_d      [NUM_CH];
    logic signed [LW-1:0] lag_sum [NUM_CH];
    logic [NW-1:0]    n_smp      [NUM_CH];
    logic [NUM_CH-1:0] adc_evt, axi_hs, strb_bad;
    logic [NUM_CH-1:0] err_lag_d, err_under_d, err_strb_d;
    logic [CNT_W-1:0] rd_adc_d, rd_axi_d, rd_trig_d;
    logic [CNT_W:0]   rd_lag_d;
    logic             trig_fire;

    assign adc_evt = en_i ? adc_we_i : '0;
    assign axi_hs  = en_i ? (axi_wvalid_i & axi_wready_i) : '0;

    // Trigger is registered once, then its rising edge is taken between the
    // registered copy and a one-cycle-delayed copy.
    assign trig_fire = en_i & trig_q & ~trig_dly_q & ~trig_seen_q;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            // Legal strobes are low-aligned runs of whole 16-bit lanes; an
            // all-zero strobe on a handshake is treated as illegal.
            n_smp[c]    = '0;
            strb_bad[c] = axi_hs[c];
            for (int k = 1; k <= LANES; k++) begin
                if (axi_hs[c] && (axi_wstrb_i[c*SW +: SW] == (ONES >> (SW - 2*k)))) begin
                    n_smp[c]    = NW'(k);
                    strb_bad[c] = 1'b0;
                end
            end
            adc_cnt_d[c] = adc_cnt_q[c] + CNT_W'(adc_evt[c]);
            axi_cnt_d[c] = axi_cnt_q[c] + CNT_W'(n_smp[c]);
            lag_sum[c]   = $signed({lag_q[c][CNT_W], lag_q[c]} + LW'(adc_evt[c]) - LW'(n_smp[c]));
            if (lag_sum[c] > LAG_HI)      lag_d[c] = LAG_HI[CNT_W:0];
            else if (lag_sum[c] < LAG_LO) lag_d[c] = LAG_LO[CNT_W:0];
            else                          lag_d[c] = lag_sum[c][CNT_W:0];
            // MAX_LAG and 0 sit inside the saturation range, so testing the
            // unsaturated sum gives the same answer as testing the stored lag.
            err_lag_d[c]   = err_lag_q[c]   | (en_i & (lag_sum[c] > LAG_MAX));
            err_under_d[c] = err_under_q[c] | (en_i & lag_sum[c][LW-1]);
            err_strb_d[c]  = err_strb_q[c]  | strb_bad[c];
        end
    end

    always_comb begin
        rd_adc_d  = '0;
        rd_axi_d  = '0;
        rd_lag_d  = '0;
        rd_trig_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch_i == RD_W'(c)) begin
                rd_adc_d  = adc_cnt_q[c];
                rd_axi_d  = axi_cnt_q[c];
                rd_lag_d  = lag_q[c];
                rd_trig_d = trig_cnt_q[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                adc_cnt_q[c]  <= '0;
                axi_cnt_q[c]  <= '0;
                lag_q[c]      <= '0;
                trig_cnt_q[c] <= '0;
            end
            err_lag_q   <= '0;
            err_under_q <= '0;
            err_strb_q  <= '0;
            trig_seen_q <= 1'b0;
            trig_q      <= 1'b0;
            trig_dly_q  <= 1'b0;
            rd_adc_q    <= '0;
            rd_axi_q    <= '0;
            rd_lag_q    <= '0;
            rd_trig_q   <= '0;
        end else begin
            trig_q     <= trig_i;
            trig_dly_q <= trig_q;
            rd_adc_q   <= rd_adc_d;
            rd_axi_q   <= rd_axi_d;
            rd_lag_q   <= rd_lag_d;
            rd_trig_q  <= rd_trig_d;
            if (clr_i) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    adc_cnt_q[c]  <= '0;
                    axi_cnt_q[c]  <= '0;
                    lag_q[c]      <= '0;
                    trig_cnt_q[c] <= '0;
                end
                err_lag_q   <= '0;
                err_under_q <= '0;
                err_strb_q  <= '0;
                trig_seen_q <= 1'b0;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    adc_cnt_q[c] <= adc_cnt_d[c];
                    axi_cnt_q[c] <= axi_cnt_d[c];
                    lag_q[c]     <= lag_d[c];
                    // Snapshot includes an ADC write landing on the edge cycle.
                    if (trig_fire) trig_cnt_q[c] <= adc_cnt_d[c];
                end
                err_lag_q   <= err_lag_d;
                err_under_q <= err_under_d;
                err_strb_q  <= err_strb_d;
                if (trig_fire) trig_seen_q <= 1'b1;
            end
        end
    end

    assign rd_adc_cnt_o  = rd_adc_q;
    assign rd_axi_cnt_o  = rd_axi_q;
    assign rd_lag_o      = rd_lag_q;
    assign rd_trig_cnt_o = rd_trig_q;
    assign trig_seen_o   = trig_seen_q;
    assign err_lag_o     = err_lag_q;
    assign err_under_o   = err_under_q;
    assign err_strb_o    = err_strb_q;

endmodule

// File: tb/tb_dma_wr_stream_checker.sv
module tb_dma_wr_stream_checker;
    localparam int NUM_CH = 4;
    localparam int AXI_DW = 64;
    localparam int CNT_W  = 32;
    localparam int SW     = AXI_DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, clr = 1'b0, trig = 1'b0;
    logic [NUM_CH-1:0]    adc_we = '0, wvalid = '0, wready = '0;
    logic [NUM_CH*SW-1:0] wstrb = '0;
    logic [1:0]           rd_ch = '0;
    logic [1:0]           rd_ch3 = '0;
    logic [CNT_W-1:0] rd_adc, rd_axi, rd_trg;
    logic [CNT_W:0]   rd_lag;
    logic             seen;
    logic [NUM_CH-1:0] e_lag, e_under, e_strb;
    // Three-channel instance: lets an out-of-range select be driven.
    logic [CNT_W-1:0] rd3_adc, rd3_axi, rd3_trg;
    logic [CNT_W:0]   rd3_lag;
    logic             seen3;
    logic [2:0]       e3_lag, e3_under, e3_strb;

    always #5 clk = ~clk;

    dma_wr_stream_checker #(.NUM_CH(NUM_CH), .AXI_DW(AXI_DW), .CNT_W(CNT_W), .MAX_LAG(256)) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
        .adc_we_i(adc_we), .axi_wvalid_i(wvalid), .axi_wready_i(wready), .axi_wstrb_i(wstrb),
        .trig_i(trig), .rd_ch_i(rd_ch),
        .rd_adc_cnt_o(rd_adc), .rd_axi_cnt_o(rd_axi), .rd_lag_o(rd_lag), .rd_trig_cnt_o(rd_trg),
        .trig_seen_o(seen), .err_lag_o(e_lag), .err_under_o(e_under), .err_strb_o(e_strb));

    dma_wr_stream_checker #(.NUM_CH(3), .AXI_DW(AXI_DW), .CNT_W(CNT_W), .MAX_LAG(256)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
        .adc_we_i(adc_we[2:0]), .axi_wvalid_i(wvalid[2:0]), .axi_wready_i(wready[2:0]),
        .axi_wstrb_i(wstrb[3*SW-1:0]), .trig_i(trig), .rd_ch_i(rd_ch3),
        .rd_adc_cnt_o(rd3_adc), .rd_axi_cnt_o(rd3_axi), .rd_lag_o(rd3_lag), .rd_trig_cnt_o(rd3_trg),
        .trig_seen_o(seen3), .err_lag_o(e3_lag), .err_under_o(e3_under), .err_strb_o(e3_strb));

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;
    exp_t sbq[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [63:0] lagv(input int v);
        logic [CNT_W:0] l;
        l = (CNT_W+1)'(v);
        return 64'(l);
    endfunction

    function automatic logic [63:0] obs(input int sel);
        case (sel)
            0:  return 64'(rd_adc);
            1:  return 64'(rd_axi);
            2:  return 64'(rd_lag);
            3:  return 64'(rd_trg);
            4:  return 64'(seen);
            5:  return 64'(e_lag);
            6:  return 64'(e_under);
            7:  return 64'(e_strb);
            8:  return 64'(rd3_adc);
            9:  return 64'(rd3_axi);
            10: return 64'(rd3_lag);
            default: return 64'(rd3_trg);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [63:0] o;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = obs(e.sel);
            n_cmp++;
            assert (o === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int ch, input int adc, input int axi, input int lag, input int trg, input string tag);
        rd_ch = 2'(ch);
        push({tag, "_adc"}, 0, 64'(adc));
        push({tag, "_axi"}, 1, 64'(axi));
        push({tag, "_lag"}, 2, lagv(lag));
        push({tag, "_trig"}, 3, 64'(trg));
        step();
        drain();
    endtask

    task automatic rd3(input int ch, input int adc, input int axi, input int lag, input string tag);
        rd_ch3 = 2'(ch);
        push({tag, "_adc"}, 8, 64'(adc));
        push({tag, "_axi"}, 9, 64'(axi));
        push({tag, "_lag"}, 10, lagv(lag));
        push({tag, "_trig"}, 11, 64'(0));
        step();
        drain();
    endtask

    task automatic flags(input logic [3:0] lg, input logic [3:0] un, input logic [3:0] sb, input logic sn, input string tag);
        push({tag, "_err_lag"}, 5, 64'(lg));
        push({tag, "_err_under"}, 6, 64'(un));
        push({tag, "_err_strb"}, 7, 64'(sb));
        push({tag, "_seen"}, 4, 64'(sn));
        drain();
    endtask

    task automatic adc(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            adc_we[ch] = 1'b1;
            step();
            adc_we = '0;
        end
    endtask

    task automatic beat(input int ch, input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            wvalid[ch] = 1'b1; wready[ch] = 1'b1;
            wstrb[ch*SW +: SW] = s;
            step();
            wvalid = '0; wready = '0; wstrb = '0;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        rd(1, 0, 0, 0, 0, "reset_rd");
        flags(4'b0, 4'b0, 4'b0, 1'b0, "reset");
        rst = 1'b0;
        en  = 1'b1;
        step();

        // 100 ADC writes vs 25 full beats on ch1
        adc(1, 100);
        beat(1, 8'hFF, 25);
        rd(1, 100, 100, 0, 0, "t1_ch1");
        flags(4'b0, 4'b0, 4'b0, 1'b0, "t1");

        // Partial-lane strobes drive ch0 lag negative
        adc(0, 3);
        beat(0, 8'h3F, 1);
        beat(0, 8'h03, 1);
        rd(0, 3, 4, -1, 0, "t2_ch0");
        flags(4'b0, 4'b0001, 4'b0, 1'b0, "t2");

        // Lag overflow on ch2, then clear
        adc(2, 257);
        rd(2, 257, 0, 257, 0, "t3_ch2");
        flags(4'b0100, 4'b0001, 4'b0, 1'b0, "t3");
        pulse_clr();
        rd(2, 0, 0, 0, 0, "t3_clr_ch2");
        rd(0, 0, 0, 0, 0, "t3_clr_ch0");
        flags(4'b0, 4'b0, 4'b0, 1'b0, "t3_clr");

        // Illegal strobes on ch3
        beat(3, 8'h0C, 1);
        beat(3, 8'h00, 1);
        rd(3, 0, 0, 0, 0, "t4_ch3");
        flags(4'b0, 4'b0, 4'b1000, 1'b0, "t4");

        // Trigger snapshot after 10 ADC writes; a second edge is ignored
        pulse_clr();
        flags(4'b0, 4'b0, 4'b0, 1'b0, "t5_clr");
        adc(0, 10);
        trig = 1'b1;
        step(); step(); step();
        flags(4'b0, 4'b0, 4'b0, 1'b1, "t5_trig");
        rd(0, 10, 0, 10, 10, "t5_ch0");
        rd(1, 0, 0, 0, 0, "t5_ch1");
        trig = 1'b0;
        step();
        adc(0, 5);
        trig = 1'b1;
        step(); step(); step();
        rd(0, 15, 0, 15, 10, "t5_retrig");

        // Same-cycle ADC write and 0x0F beat on ch1
        adc(1, 3);
        adc_we[1] = 1'b1;
        beat(1, 8'h0F, 1);
        adc_we = '0;
        rd(1, 4, 2, 2, 0, "t5_simul");

        // en low: events and bad strobes ignored
        en = 1'b0;
        adc_we[1] = 1'b1;
        beat(1, 8'h0C, 1);
        adc_we = '0;
        en = 1'b1;
        rd(1, 4, 2, 2, 0, "en_low_ch1");
        flags(4'b0, 4'b0, 4'b0, 1'b1, "en_low");

        // Read-back select past the channel count returns zeros
        rd3(3, 0, 0, 0, "rd_oor");
        rd3(1, 4, 2, 2, "rd3_ch1");

        // Reset mid-stream, with clear and events all active
        beat(2, 8'hFF, 1);
        flags(4'b0, 4'b0100, 4'b0, 1'b1, "pre_rst");
        adc_we = '1; wvalid = '1; wready = '1; wstrb = '1;
        clr = 1'b1; rst = 1'b1;
        rd(1, 0, 0, 0, 0, "rst_mid");
        flags(4'b0, 4'b0, 4'b0, 1'b0, "rst_mid");
        adc_we = '0; wvalid = '0; wready = '0; wstrb = '0;
        clr = 1'b0; rst = 1'b0;
        step();
        rd(1, 0, 0, 0, 0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
